// File: rtl/seg_scan_rx.sv
// seg_scan_rx
// Receive side of the active-low 7-segment digit interface. The block samples
// the multiplexed display bus, turns each digit's segment pattern back into a
// 4-bit code, and commits a code only after it has been seen on STABLE_CNT
// consecutive samples of that digit.
//
// Build option: define SEG_SCAN_BLANK_EN so that the all-off pattern (0x7F)
// decodes to the legal code 0xA. Without it, 0x7F is an illegal pattern.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          asynchronous reset, active high
//   seg_n_i[6:0]   segment lines, active low, bit6..bit0 = a..g
//   an_n_i         digit enables, active low, bit i selects digit i
//   sample_en_i    bus is evaluated only on edges where this is high
//   digits_o       committed codes, digit i at [4i+3:4i]
//   digit_valid_o  committed code of digit i is a legal digit
//   digit_err_o    digit i last stabilised on an illegal pattern
//   update_o       one-cycle pulse when any digits/valid/err bit changes
//   bus_err_o      one-cycle pulse when a strobed an_n_i is not one-hot low
module seg_scan_rx #(
   parameter int NDIGITS    = 4,
   parameter int STABLE_CNT = 3
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [6:0]             seg_n_i,
   input  logic [NDIGITS-1:0]     an_n_i,
   input  logic                   sample_en_i,
   output logic [4*NDIGITS-1:0]   digits_o,
   output logic [NDIGITS-1:0]     digit_valid_o,
   output logic [NDIGITS-1:0]     digit_err_o,
   output logic                   update_o,
   output logic                   bus_err_o
);

   localparam int CW = $clog2(STABLE_CNT + 1);
   localparam logic [CW-1:0] SAT    = CW'(STABLE_CNT);
   localparam logic [CW-1:0] SAT_M1 = CW'(STABLE_CNT - 1);
   localparam logic [CW-1:0] ONE    = CW'(1);
   localparam logic [3:0]    ILLEGAL = 4'hF;

   function automatic logic [3:0] decode(input logic [6:0] pat);
      logic [3:0] code;
      code = ILLEGAL;
      case (pat)
         7'h01: code = 4'd0;
         7'h4F: code = 4'd1;
         7'h12: code = 4'd2;
         7'h06: code = 4'd3;
         7'h4C: code = 4'd4;
         7'h24: code = 4'd5;
         7'h20: code = 4'd6;
         7'h0F: code = 4'd7;
         7'h00: code = 4'd8;
         7'h04: code = 4'd9;
`ifdef SEG_SCAN_BLANK_EN
         7'h7F: code = 4'hA;
`endif
         default: code = ILLEGAL;
      endcase
      return code;
   endfunction

   logic [NDIGITS-1:0][3:0]    cand_q, cand_d;
   logic [NDIGITS-1:0][CW-1:0] cnt_q, cnt_d;
   logic [NDIGITS-1:0][3:0]    dig_q, dig_d;
   logic [NDIGITS-1:0]         val_q, val_d;
   logic [NDIGITS-1:0]         err_q, err_d;
   logic                       upd_q, upd_d;
   logic                       bus_err_q, bus_err_d;

   logic [NDIGITS-1:0] sel;
   logic               onehot;
   logic               accept;
   logic [3:0]         code;
   logic [NDIGITS-1:0] commit;

   assign sel    = ~an_n_i;
   // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
   assign onehot = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
   assign accept = sample_en_i && onehot;
   assign code   = decode(seg_n_i);

   always_comb begin
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      dig_d     = dig_q;
      val_d     = val_q;
      err_d     = err_q;
      commit    = '0;
      bus_err_d = sample_en_i && !onehot;

      for (int i = 0; i < NDIGITS; i++) begin
         if (accept && sel[i]) begin
            if (code == cand_q[i]) begin
               if (cnt_q[i] != SAT) cnt_d[i] = cnt_q[i] + ONE;
               // Commit only on the step into saturation, never while parked there.
               commit[i] = (cnt_q[i] == SAT_M1);
            end else begin
               cand_d[i] = code;
               cnt_d[i]  = ONE;
               commit[i] = (STABLE_CNT == 1);
            end
            if (commit[i]) begin
               if (code != ILLEGAL) begin
                  dig_d[i] = code;
                  val_d[i] = 1'b1;
                  err_d[i] = 1'b0;
               end else begin
                  val_d[i] = 1'b0;
                  err_d[i] = 1'b1;
               end
            end
         end
      end

      upd_d = (dig_d != dig_q) || (val_d != val_q) || (err_d != err_q);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cand_q    <= '0;
         cnt_q     <= '0;
         dig_q     <= '0;
         val_q     <= '0;
         err_q     <= '0;
         upd_q     <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         dig_q     <= dig_d;
         val_q     <= val_d;
         err_q     <= err_d;
         upd_q     <= upd_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign digits_o      = dig_q;
   assign digit_valid_o = val_q;
   assign digit_err_o   = err_q;
   assign update_o      = upd_q;
   assign bus_err_o     = bus_err_q;

endmodule

// File: tb/tb_seg_scan_rx.sv
module tb_seg_scan_rx;

   localparam int NDIGITS    = 4;
   localparam int STABLE_CNT = 3;

   logic                 clk_i = 1'b0;
   logic                 rst_i = 1'b0;
   logic [6:0]           seg_n_i = 7'h7F;
   logic [NDIGITS-1:0]   an_n_i = '1;
   logic                 sample_en_i = 1'b0;
   logic [4*NDIGITS-1:0] digits_o;
   logic [NDIGITS-1:0]   digit_valid_o;
   logic [NDIGITS-1:0]   digit_err_o;
   logic                 update_o;
   logic                 bus_err_o;

   seg_scan_rx #(.NDIGITS(NDIGITS), .STABLE_CNT(STABLE_CNT)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .seg_n_i       (seg_n_i),
      .an_n_i        (an_n_i),
      .sample_en_i   (sample_en_i),
      .digits_o      (digits_o),
      .digit_valid_o (digit_valid_o),
      .digit_err_o   (digit_err_o),
      .update_o      (update_o),
      .bus_err_o     (bus_err_o)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;
   int n_upd   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: per-digit candidate/count and committed outputs.
   logic [6:0] pat_tbl [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                                7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};
   int m_cand [NDIGITS];
   int m_cnt  [NDIGITS];
   int m_dig  [NDIGITS];
   bit m_val  [NDIGITS];
   bit m_err  [NDIGITS];
   bit m_upd;
   bit m_bus;

   function automatic int ref_decode(input logic [6:0] p);
      for (int k = 0; k < 10; k++) if (pat_tbl[k] == p) return k;
`ifdef SEG_SCAN_BLANK_EN
      if (p == 7'h7F) return 10;
`endif
      return 15;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NDIGITS; i++) begin
         m_cand[i] = 0; m_cnt[i] = 0; m_dig[i] = 0; m_val[i] = 0; m_err[i] = 0;
      end
      m_upd = 0; m_bus = 0;
   endtask

   task automatic model_step(input bit en, input logic [NDIGITS-1:0] an, input logic [6:0] seg);
      int lows, d, c, old_dig;
      bit reached, old_val, old_err;
      m_upd = 0; m_bus = 0;
      if (!en) return;
      lows = 0; d = 0;
      for (int i = 0; i < NDIGITS; i++) if (!an[i]) begin lows++; d = i; end
      if (lows != 1) begin m_bus = 1; return; end
      c = ref_decode(seg);
      if (c == m_cand[d]) begin
         reached = (m_cnt[d] < STABLE_CNT) && (m_cnt[d] + 1 == STABLE_CNT);
         if (m_cnt[d] < STABLE_CNT) m_cnt[d]++;
      end else begin
         m_cand[d] = c;
         m_cnt[d]  = 1;
         reached   = (STABLE_CNT == 1);
      end
      if (reached) begin
         old_dig = m_dig[d]; old_val = m_val[d]; old_err = m_err[d];
         if (c != 15) begin m_dig[d] = c; m_val[d] = 1; m_err[d] = 0; end
         else begin m_val[d] = 0; m_err[d] = 1; end
         m_upd = (old_dig != m_dig[d]) || (old_val != m_val[d]) || (old_err != m_err[d]);
      end
   endtask

   function automatic logic [31:0] exp_digits();
      logic [31:0] v = '0;
      for (int i = 0; i < NDIGITS; i++) v[4*i +: 4] = 4'(m_dig[i]);
      return v;
   endfunction

   function automatic logic [31:0] exp_val();
      logic [31:0] v = '0;
      for (int i = 0; i < NDIGITS; i++) v[i] = m_val[i];
      return v;
   endfunction

   function automatic logic [31:0] exp_err();
      logic [31:0] v = '0;
      for (int i = 0; i < NDIGITS; i++) v[i] = m_err[i];
      return v;
   endfunction

   task automatic check_all(input string where);
      chk({where, ".digits"}, 32'(digits_o), exp_digits());
      chk({where, ".valid"},  32'(digit_valid_o), exp_val());
      chk({where, ".err"},    32'(digit_err_o), exp_err());
      chk({where, ".update"}, 32'(update_o), 32'(m_upd));
      chk({where, ".bus_err"}, 32'(bus_err_o), 32'(m_bus));
   endtask

   // One clock: drive at negedge, model the posedge, check at the next negedge.
   task automatic cyc(input string where, input bit en, input logic [NDIGITS-1:0] an,
                      input logic [6:0] seg);
      sample_en_i = en; an_n_i = an; seg_n_i = seg;
      @(posedge clk_i);
      model_step(en, an, seg);
      @(negedge clk_i);
      if (update_o === 1'b1) n_upd++;
      check_all(where);
   endtask

   task automatic dig_sample(input string where, input int d, input logic [6:0] seg);
      logic [NDIGITS-1:0] an = '1;
      an[d] = 1'b0;
      cyc(where, 1'b1, an, seg);
   endtask

   logic [6:0] scan_seg [4] = '{7'h06, 7'h0F, 7'h01, 7'h24};
   logic [6:0] cur_pat [NDIGITS];

   initial begin
      logic [31:0] v;
      model_reset();
      rst_i = 1'b1;
      #12;
      chk("reset.digits", 32'(digits_o), 32'h0);
      chk("reset.valid",  32'(digit_valid_o), 32'h0);
      chk("reset.update", 32'(update_o), 32'h0);
      chk("reset.bus_err", 32'(bus_err_o), 32'h0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);

      // Three full scan rounds.
      n_upd = 0;
      for (int r = 0; r < 3; r++)
         for (int d = 0; d < NDIGITS; d++) dig_sample("scan", d, scan_seg[d]);
      chk("scan.digits_const", 32'(digits_o), 32'h5073);
      chk("scan.valid_const", 32'(digit_valid_o), 32'hF);
      chk("scan.n_update", 32'(n_upd), 32'd4);

      // Digit0: 3,3 (saturated, no recommit) then 5 x3.
      n_upd = 0;
      dig_sample("d0_seq", 0, 7'h06);
      dig_sample("d0_seq", 0, 7'h06);
      dig_sample("d0_seq", 0, 7'h24);
      dig_sample("d0_seq", 0, 7'h24);
      chk("d0_seq.not_yet", 32'(digits_o[3:0]), 32'h3);
      dig_sample("d0_seq", 0, 7'h24);
      chk("d0_seq.committed", 32'(digits_o[3:0]), 32'h5);
      chk("d0_seq.n_update", 32'(n_upd), 32'd1);

      // Digit1: illegal then back to 1.
      for (int k = 0; k < 3; k++) dig_sample("d1_bad", 1, 7'h08);
      chk("d1_bad.err", 32'(digit_err_o[1]), 32'h1);
      chk("d1_bad.hold", 32'(digits_o[7:4]), 32'h7);
      for (int k = 0; k < 3; k++) dig_sample("d1_one", 1, 7'h4F);
      chk("d1_one.code", 32'(digits_o[7:4]), 32'h1);
      chk("d1_one.valid", 32'(digit_valid_o[1]), 32'h1);

      // Bus errors interrupting a run on digit3.
      dig_sample("bus", 3, 7'h06);
      dig_sample("bus", 3, 7'h06);
      cyc("bus_c", 1'b1, 4'hC, 7'h24);
      chk("bus_c.pulse", 32'(bus_err_o), 32'h1);
      cyc("bus_f", 1'b1, 4'hF, 7'h24);
      chk("bus_f.pulse", 32'(bus_err_o), 32'h1);
      cyc("idle", 1'b0, 4'h7, 7'h24);
      dig_sample("bus", 3, 7'h06);
      chk("bus.commit", 32'(digits_o[15:12]), 32'h3);

      // Blank pattern on digit2.
      for (int k = 0; k < 3; k++) dig_sample("blank", 2, 7'h7F);
`ifdef SEG_SCAN_BLANK_EN
      chk("blank.code", 32'(digits_o[11:8]), 32'hA);
      chk("blank.valid", 32'(digit_valid_o[2]), 32'h1);
`else
      chk("blank.err", 32'(digit_err_o[2]), 32'h1);
      chk("blank.valid", 32'(digit_valid_o[2]), 32'h0);
`endif

      // Async reset between the 2nd and 3rd samples of a run.
      dig_sample("rst_run", 0, 7'h4C);
      dig_sample("rst_run", 0, 7'h4C);
      sample_en_i = 1'b0;
      #2 rst_i = 1'b1;
      #1;
      model_reset();
      chk("async.digits", 32'(digits_o), 32'h0);
      chk("async.valid", 32'(digit_valid_o), 32'h0);
      chk("async.err", 32'(digit_err_o), 32'h0);
      @(negedge clk_i);
      rst_i = 1'b0;
      dig_sample("post_rst", 0, 7'h4C);
      dig_sample("post_rst", 0, 7'h4C);
      chk("post_rst.no_commit", 32'(digits_o[3:0]), 32'h0);
      dig_sample("post_rst", 0, 7'h4C);
      chk("post_rst.commit", 32'(digits_o[3:0]), 32'h4);

      // Randomized interleaved traffic.
      for (int i = 0; i < NDIGITS; i++) cur_pat[i] = pat_tbl[$urandom_range(9)];
      for (int n = 0; n < 600; n++) begin
         int d;
         logic [NDIGITS-1:0] an;
         d = $urandom_range(NDIGITS - 1);
         if ($urandom_range(5) == 0) begin
            case ($urandom_range(3))
               0: cur_pat[d] = 7'($urandom);
               1: cur_pat[d] = 7'h7F;
               default: cur_pat[d] = pat_tbl[$urandom_range(9)];
            endcase
         end
         an = '1;
         an[d] = 1'b0;
         if ($urandom_range(15) == 0) an = NDIGITS'($urandom);
         cyc("rand", ($urandom_range(7) != 0), an, cur_pat[d]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
